pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch front end feeding the decode/execute stages whose system ops drive the CSR/trap unit. Owns the architectural PC and issues one instruction-bus read at a time. Applies redirects from the CSR unit (trap_en/trap_pc for exceptions, xRET and SATP-write refetch) and from branch resolution (br_en/br_pc). Delivers one instruction per handshake to decode, flagging misaligned targets so decode raises fetch-misaligned exception cause 0.

## Interface
- RESET_PC, 64'h0000_0000_0000_1000, PC value after reset.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- trap_en  in  1  CSR-unit redirect request, highest priority
- trap_pc  in  64  CSR-unit redirect target
- br_en  in  1  branch/jump redirect request
- br_pc  in  64  branch target
- ibus_req  out  1  read request
- ibus_addr  out  64  read address (equals pc)
- ibus_gnt  in  1  request accepted this cycle
- ibus_rvalid  in  1  read data valid
- ibus_rdata  in  32  instruction word
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts instruction
- id_inst  out  32  instruction word
- id_pc  out  64  PC of id_inst
- id_misalign  out  1  id_pc[1:0] != 0; id_inst is a NOP

## Operation
- Registers: pc (64), inst_q (32), misalign_q (1), state in {FETCH, WAIT, HOLD, DRAIN}.
- Redirect: redir = trap_en | br_en; target = trap_en ? trap_pc : br_pc. trap_en wins when both are asserted.
- FETCH: ibus_req=1, ibus_addr=pc.
  - redir & gnt: pc<=target, go to DRAIN. The granted response is stale.
  - redir & ~gnt: pc<=target, stay in FETCH. Address changes while ungranted; the bus permits this.
  - gnt: go to WAIT.
- Misaligned target: when a redirect target has target[1:0]!=0, set pc<=target, misalign_q<=1, inst_q<=32'h0000_0013, and go directly to HOLD with no bus access.
  - Exception: if that redirect occurs in FETCH with gnt, go to DRAIN first; after the drain completes, go to HOLD instead of FETCH.
- WAIT: ibus_req=0.
  - redir & rvalid: discard data, pc<=target, go to FETCH (or HOLD if misaligned).
  - redir & ~rvalid: pc<=target, go to DRAIN.
  - rvalid: inst_q<=ibus_rdata, misalign_q<=0, go to HOLD.
- HOLD: id_valid = ~redir, id_inst=inst_q, id_pc=pc, id_misalign=misalign_q.
  - redir: pc<=target, go to FETCH (or re-enter HOLD if misaligned).
  - id_ready: pc<=pc+4 (64-bit wrap at 2^64), go to FETCH.
  - otherwise hold all outputs stable.
- DRAIN: ibus_req=0; wait for rvalid and discard it, then go to FETCH (or HOLD if misalign_q was set). A redirect in DRAIN updates pc (and misalign_q) and stays in DRAIN.
- At most one outstanding bus transaction at all times. rvalid in FETCH or HOLD is a protocol violation; assert it in simulation.

## Timing
- Reset (asynchronous): pc=RESET_PC, state=FETCH, inst_q=0, misalign_q=0. Outputs during reset: ibus_req=0 (gated by rst_n), ibus_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=RESET_PC, id_misalign=0.
- First ibus_req occurs the first cycle after rst_n deasserts.
- Best case is 3 cycles per instruction: FETCH with gnt, WAIT with rvalid, HOLD with id_ready.
- id_valid is combinationally gated by redir. A redirect in the same cycle as id_ready therefore never transfers an instruction.
- Redirect to first request at the new target: 1 cycle from FETCH/WAIT/HOLD with no stale data. In DRAIN it is 1 cycle after the stale rvalid.
- Reset mid-transaction returns to FETCH at RESET_PC. The bus shares rst_n, so no stale rvalid follows reset.

## Test plan
- Reset release, gnt and rvalid each next cycle, id_ready=1 -> fetches at 0x1000, 0x1004, 0x1008; id_pc matches; one instruction per 3 cycles.
- id_ready=0 for 5 cycles in HOLD -> id_valid, id_inst, id_pc stable; no ibus_req; pc advances by 4 only on acceptance.
- Trap during WAIT (trap_pc=0x8000_0000), rvalid 2 cycles later -> data discarded, DRAIN, next ibus_addr=0x8000_0000, id_valid never shows stale word.
- trap_en and br_en in the same HOLD cycle (trap_pc=0x2000, br_pc=0x3000) -> id_valid=0 that cycle, next fetch at 0x2000.
- br_pc=0x1002 -> no bus request; id_valid=1, id_misalign=1, id_inst=0x00000013, id_pc=0x1002.
- Redirect coinciding with gnt in FETCH, then rst_n pulse during DRAIN -> after reset, ibus_addr=RESET_PC, no stale instruction delivered.

Source files
------------

// File: rtl/pc_fetch_if.sv
`default_nettype none
// =============================================================================
// Module   : pc_fetch_if
// Brief    : Redirect, instruction-bus and decode-handshake signals of pc_fetch.
// Revision : 1.0
// =============================================================================
interface pc_fetch_if;
    logic        trap_en;
    logic [63:0] trap_pc;
    logic        br_en;
    logic [63:0] br_pc;
    logic        ibus_req;
    logic [63:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        id_misalign;

    modport master (
        input  trap_en, trap_pc, br_en, br_pc,
        input  ibus_gnt, ibus_rvalid, ibus_rdata, id_ready,
        output ibus_req, ibus_addr, id_valid, id_inst, id_pc, id_misalign
    );

    modport slave (
        output trap_en, trap_pc, br_en, br_pc,
        output ibus_gnt, ibus_rvalid, ibus_rdata, id_ready,
        input  ibus_req, ibus_addr, id_valid, id_inst, id_pc, id_misalign
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// =============================================================================
// Module   : pc_fetch
// Brief    : Instruction-fetch front end: owns the PC, keeps one bus read in
//            flight, applies trap/branch redirects and feeds decode.
// Revision : 1.0
// =============================================================================
module pc_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_1000
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [31:0] c_nop_inst = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        misalign_q, misalign_d;

    logic        w_redir;
    logic [63:0] w_target;
    logic        w_tgt_mis;

    assign w_redir   = bus.trap_en | bus.br_en;
    assign w_target  = bus.trap_en ? bus.trap_pc : bus.br_pc;
    assign w_tgt_mis = |w_target[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        misalign_d = misalign_q;

        // Any redirect retargets the PC; a misaligned target is served as a NOP.
        if (w_redir) begin
            pc_d       = w_target;
            misalign_d = w_tgt_mis;
            if (w_tgt_mis) begin
                inst_d = c_nop_inst;
            end
        end

        case (state_q)
            S_FETCH: begin
                if (w_redir) begin
                    if (bus.ibus_gnt)   state_d = S_DRAIN;
                    else if (w_tgt_mis) state_d = S_HOLD;
                    else                state_d = S_FETCH;
                end else if (bus.ibus_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redir) begin
                    if (!bus.ibus_rvalid) state_d = S_DRAIN;
                    else if (w_tgt_mis)   state_d = S_HOLD;
                    else                  state_d = S_FETCH;
                end else if (bus.ibus_rvalid) begin
                    inst_d     = bus.ibus_rdata;
                    misalign_d = 1'b0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    state_d = w_tgt_mis ? S_HOLD : S_FETCH;
                end else if (bus.id_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // misalign_d already reflects a redirect landing in this cycle.
                if (bus.ibus_rvalid) begin
                    state_d = misalign_d ? S_HOLD : S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.ibus_req    = rst_n & (state_q == S_FETCH);
    assign bus.ibus_addr   = pc_q;
    assign bus.id_valid    = (state_q == S_HOLD) & ~w_redir;
    assign bus.id_inst     = inst_q;
    assign bus.id_pc       = pc_q;
    assign bus.id_misalign = misalign_q;

    // Read data may only return while a transaction is outstanding.
    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        bus.ibus_rvalid |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// =============================================================================
// Module   : tb_pc_fetch
// Brief    : Directed and random stimulus for pc_fetch with a scoreboard of
//            expected decode deliveries and a randomized-latency bus model.
// Revision : 1.0
// =============================================================================
module tb_pc_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;

    pc_fetch_if bus();

    pc_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } item_t;

    item_t       exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          hs_cyc[$];
    logic [63:0] hs_pc[$];

    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] m;
        m = a[31:0] * 32'h9E37_79B1;
        return m ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    // What decode must see for an instruction fetched at address a.
    function automatic item_t expect_at(input logic [63:0] a);
        item_t it;
        it.pc   = a;
        it.mis  = (a[1:0] != 2'b00);
        it.inst = it.mis ? NOP : mem_word(a);
        return it;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        failures++;
        $display("FAIL %s", msg);
    endtask

    // ---------------- instruction bus model ----------------
    initial begin
        bit          pend;
        int          cnt;
        logic [63:0] paddr;
        pend = 1'b0; cnt = 0; paddr = '0;
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b0; bus.ibus_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend = 1'b0;
                bus.ibus_gnt = 1'b0;
                bus.ibus_rvalid = 1'b0;
            end else begin
                bus.ibus_rvalid = pend && (cnt == 0);
                bus.ibus_rdata  = bus.ibus_rvalid ? mem_word(paddr) : 32'hDEAD_BEEF;
                bus.ibus_gnt    = ($urandom_range(1, 100) <= gnt_pct);
                if (bus.ibus_rvalid) pend = 1'b0;
                else if (pend)       cnt--;
                if (bus.ibus_req && bus.ibus_gnt) begin
                    check("one_outstanding", 64'(pend), 64'd0);
                    pend  = 1'b1;
                    paddr = bus.ibus_addr;
                    cnt   = int'($urandom_range(lat_min, lat_max)) - 1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int    idle;
        item_t e;
        idle = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                idle = 0;
            end else begin
                cyc++;
                if (bus.id_valid) begin
                    idle = 0;
                    check("valid_gated_by_redirect", 64'(bus.trap_en | bus.br_en), 64'd0);
                    if (exp_q.size() == 0) begin
                        fail_now($sformatf("unexpected_delivery: pc %h with nothing expected", bus.id_pc));
                    end else begin
                        e = exp_q[0];
                        check("id_pc", bus.id_pc, e.pc);
                        check("id_inst", 64'(bus.id_inst), 64'(e.inst));
                        check("id_misalign", 64'(bus.id_misalign), 64'(e.mis));
                        if (bus.id_ready) begin
                            void'(exp_q.pop_front());
                            hs_cyc.push_back(cyc);
                            hs_pc.push_back(e.pc);
                            exp_q.push_back(expect_at(e.pc + 64'd4));
                        end
                    end
                end else if (bus.trap_en | bus.br_en) begin
                    idle = 0;
                end else begin
                    idle++;
                    if (idle > 80) begin
                        fail_now($sformatf("stall: no instruction for %0d cycles", idle));
                        idle = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        bus.trap_en = 1'b0;
        bus.br_en   = 1'b0;
    endtask

    task automatic redirect(input bit t, input logic [63:0] tpc, input bit b, input logic [63:0] bpc);
        bus.trap_en = t;
        bus.trap_pc = tpc;
        bus.br_en   = b;
        bus.br_pc   = bpc;
        exp_q.delete();
        exp_q.push_back(expect_at(t ? tpc : bpc));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.trap_en = 1'b0; bus.br_en = 1'b0; bus.id_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_ibus_req", 64'(bus.ibus_req), 64'd0);
        check("rst_ibus_addr", bus.ibus_addr, RESET_PC);
        check("rst_id_valid", 64'(bus.id_valid), 64'd0);
        check("rst_id_inst", 64'(bus.id_inst), 64'd0);
        check("rst_id_pc", bus.id_pc, RESET_PC);
        check("rst_id_misalign", 64'(bus.id_misalign), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(expect_at(RESET_PC));
        hs_cyc.delete();
        hs_pc.delete();
        #2;
        check("first_req", 64'(bus.ibus_req), 64'd1);
        check("first_addr", bus.ibus_addr, RESET_PC);
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            #2;
            if (bus.id_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("%s: id_valid timeout", name));
    endtask

    task automatic wait_fetch(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.ibus_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("%s: ibus_req timeout", name));
    endtask

    function automatic logic [63:0] rand_target();
        int unsigned r;
        logic [63:0] base;
        r    = $urandom_range(0, 15);
        base = 64'h1000 + 64'(4 * $urandom_range(0, 1023));
        if (r == 0)      return base | 64'($urandom_range(1, 3));
        else if (r == 1) return 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
        else if (r == 2) return {32'($urandom), base[31:0]};
        else             return base;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] pc0;
        logic [31:0] inst0;
        int          n;
        bit          seen;
        bit          mis_pending;
        int          mis_wait;
        logic [63:0] tp, bp;
        int unsigned kind;

        bus.trap_en = 1'b0; bus.br_en = 1'b0;
        bus.trap_pc = '0;   bus.br_pc = '0;
        bus.id_ready = 1'b0;
        rst_n = 1'b1;
        #1;

        // Best case throughput from reset.
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        bus.id_ready = 1'b1;
        repeat (10) step();
        if (hs_pc.size() < 3) begin
            fail_now($sformatf("best_case_count: %0d deliveries, need 3", hs_pc.size()));
        end else begin
            check("bc_pc0", hs_pc[0], RESET_PC);
            check("bc_pc1", hs_pc[1], RESET_PC + 64'd4);
            check("bc_pc2", hs_pc[2], RESET_PC + 64'd8);
            check("bc_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
            check("bc_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
        end

        // Decode stalls for 5 cycles in HOLD.
        bus.id_ready = 1'b0;
        wait_valid("stall");
        pc0   = bus.id_pc;
        inst0 = bus.id_inst;
        repeat (5) begin
            step();
            #2;
            check("stall_valid", 64'(bus.id_valid), 64'd1);
            check("stall_pc", bus.id_pc, pc0);
            check("stall_inst", 64'(bus.id_inst), 64'(inst0));
            check("stall_no_req", 64'(bus.ibus_req), 64'd0);
        end
        step();
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        #2;
        check("accept_req", 64'(bus.ibus_req), 64'd1);
        check("accept_addr", bus.ibus_addr, pc0 + 64'd4);

        // Trap while waiting on read data; data returns two cycles later.
        lat_min = 3; lat_max = 3;
        bus.id_ready = 1'b1;
        wait_fetch("trap_wait_fetch");
        step();
        redirect(1'b1, 64'h0000_0000_8000_0000, 1'b0, 64'h0);
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            #2;
            if (bus.ibus_req) begin
                n = i;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("trap_wait: no refetch");
        check("trap_wait_addr", bus.ibus_addr, 64'h0000_0000_8000_0000);
        check("trap_wait_latency", 64'(n), 64'd3);

        // Trap and branch in the same HOLD cycle.
        lat_min = 1; lat_max = 1;
        bus.id_ready = 1'b0;
        wait_valid("dual_redirect");
        step();
        redirect(1'b1, 64'h2000, 1'b1, 64'h3000);
        #2;
        check("dual_valid_low", 64'(bus.id_valid), 64'd0);
        step();
        #2;
        check("dual_req", 64'(bus.ibus_req), 64'd1);
        check("dual_addr", bus.ibus_addr, 64'h2000);

        // Misaligned branch target is served without a bus access.
        wait_valid("misalign");
        step();
        redirect(1'b0, 64'h0, 1'b1, 64'h1002);
        repeat (4) begin
            step();
            #2;
            check("mis_no_req", 64'(bus.ibus_req), 64'd0);
            check("mis_valid", 64'(bus.id_valid), 64'd1);
            check("mis_flag", 64'(bus.id_misalign), 64'd1);
            check("mis_inst", 64'(bus.id_inst), 64'(NOP));
            check("mis_pc", bus.id_pc, 64'h1002);
        end
        step();
        redirect(1'b1, 64'h1000, 1'b0, 64'h0);

        // Redirect on a granted fetch, then reset during the drain.
        lat_min = 4; lat_max = 4;
        bus.id_ready = 1'b1;
        wait_fetch("drain_reset_fetch");
        redirect(1'b0, 64'h0, 1'b1, 64'h4000);
        step();
        apply_reset();
        lat_min = 1; lat_max = 2;
        bus.id_ready = 1'b1;
        repeat (12) step();
        if (hs_pc.size() < 1) fail_now("post_reset: no delivery");
        else check("post_reset_pc", hs_pc[0], RESET_PC);

        // Random traffic.
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        mis_pending = 1'b0;
        mis_wait = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (mis_pending) begin
                bus.id_ready = 1'b0;
                if (mis_wait == 0) begin
                    redirect(1'b1, 64'h1000 + 64'(4 * $urandom_range(0, 255)), 1'b0, rand_target());
                    mis_pending = 1'b0;
                end else begin
                    mis_wait--;
                end
            end else begin
                bus.id_ready = ($urandom_range(0, 99) < 70);
                if ($urandom_range(0, 99) < 8) begin
                    tp   = rand_target();
                    bp   = rand_target();
                    kind = $urandom_range(0, 2);
                    redirect(kind != 1, tp, kind != 0, bp);
                    if (((kind != 1) ? tp[1:0] : bp[1:0]) != 2'b00) begin
                        mis_pending = 1'b1;
                        mis_wait = int'($urandom_range(1, 5));
                    end
                end
            end
        end
        step();
        bus.id_ready = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
